// File: rtl/fir_pkg.sv
// Shared definitions for the FIR input-side stream writer: FSM encoding and
// data RAM geometry constants.
package fir_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CLEAR   = 3'd1,
      ST_WAIT_IN = 3'd2,
      ST_WRITE   = 3'd3,
      ST_NOTIFY  = 3'd4,
      ST_DONE    = 3'd5
   } state_e;

   localparam int          TAP_NUM   = 11;
   localparam logic [11:0] LAST_ADDR = 12'h028;
   localparam logic [11:0] ADDR_STEP = 12'h004;
   localparam logic [3:0]  WE_ALL    = 4'hF;

endpackage

// File: rtl/fir_wrap_ptr.sv
// Byte-address pointer into the circular data RAM: synchronous clear,
// step by STEP, and wrap from LAST back to zero.
module fir_wrap_ptr
   import fir_pkg::*;
#(
   parameter int           W    = 12,
   parameter logic [W-1:0] LAST = W'(LAST_ADDR),
   parameter logic [W-1:0] STEP = W'(ADDR_STEP)
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         clr_i,
   input  logic         step_i,
   output logic [W-1:0] ptr_o
);

   logic [W-1:0] ptr_q, ptr_d;

   // Clear has priority so a new run always starts at address zero.
   always_comb begin
      ptr_d = ptr_q;
      if (clr_i)
         ptr_d = '0;
      else if (step_i)
         ptr_d = (ptr_q == LAST) ? '0 : ptr_q + STEP;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values of its neighbours.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         ptr_q <= '0;
      else
         ptr_q <= ptr_d;
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/fir_data_writer.sv
// AXI-Stream slave to circular data RAM writer for the FIR core: clears the
// RAM, then writes one sample at a time and hands it to the address generator.
module fir_data_writer
   import fir_pkg::*;
#(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32,
   parameter int Tape_Num    = TAP_NUM
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst_n,
   input  logic                   ap_start,
   input  logic [31:0]            data_length,
   input  logic                   ss_tvalid,
   input  logic [pDATA_WIDTH-1:0] ss_tdata,
   input  logic                   ss_tlast,
   output logic                   ss_tready,
   output logic                   data_EN,
   output logic [3:0]             data_WE,
   output logic [pADDR_WIDTH-1:0] data_A,
   output logic [pDATA_WIDTH-1:0] data_Di,
   output logic                   smp_valid,
   output logic [pADDR_WIDTH-1:0] smp_head,
   input  logic                   smp_ready,
   output logic                   ap_done,
   output logic                   tlast_err
);

   localparam logic [pADDR_WIDTH-1:0] RAM_LAST = pADDR_WIDTH'(4 * (Tape_Num - 1));
   localparam logic [pADDR_WIDTH-1:0] RAM_STEP = pADDR_WIDTH'(ADDR_STEP);

   state_e                 state_q;
   logic [31:0]            len_q;
   logic [31:0]            cnt_q;
   logic [pDATA_WIDTH-1:0] sample_q;
   logic                   last_q;
   logic                   tlast_err_q;

   logic [pADDR_WIDTH-1:0] clr_ptr;
   logic [pADDR_WIDTH-1:0] head;

   // 33-bit increment so data_length = 0xFFFFFFFF compares without wrapping.
   logic [32:0] cnt_inc;
   logic        len_hit;
   logic        run_start;
   logic        smp_taken;
   logic        run_end;

   assign cnt_inc   = {1'b0, cnt_q} + 33'd1;
   assign len_hit   = (cnt_inc == {1'b0, len_q});
   assign run_start = (state_q == ST_IDLE) && ap_start;
   assign smp_taken = (state_q == ST_NOTIFY) && smp_ready;
   assign run_end   = len_hit || last_q;

   fir_wrap_ptr #(
      .W    (pADDR_WIDTH),
      .LAST (RAM_LAST),
      .STEP (RAM_STEP)
   ) u_clr_ptr (
      .clk_i   (axis_clk),
      .rst_n_i (axis_rst_n),
      .clr_i   (run_start),
      .step_i  (state_q == ST_CLEAR),
      .ptr_o   (clr_ptr)
   );

   fir_wrap_ptr #(
      .W    (pADDR_WIDTH),
      .LAST (RAM_LAST),
      .STEP (RAM_STEP)
   ) u_head (
      .clk_i   (axis_clk),
      .rst_n_i (axis_rst_n),
      .clr_i   (run_start),
      .step_i  (smp_taken && !run_end),
      .ptr_o   (head)
   );

   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         cnt_q       <= '0;
         sample_q    <= '0;
         last_q      <= 1'b0;
         tlast_err_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (ap_start) begin
                  len_q       <= data_length;
                  cnt_q       <= '0;
                  tlast_err_q <= 1'b0;
                  state_q     <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               if (clr_ptr == RAM_LAST)
                  state_q <= (len_q == 32'd0) ? ST_DONE : ST_WAIT_IN;
            end
            ST_WAIT_IN: begin
               if (ss_tvalid) begin
                  sample_q <= ss_tdata;
                  last_q   <= ss_tlast;
                  state_q  <= ST_WRITE;
               end
            end
            ST_WRITE: state_q <= ST_NOTIFY;
            ST_NOTIFY: begin
               if (smp_ready) begin
                  cnt_q <= cnt_inc[31:0];
                  // Early tlast or a missing tlast on the final sample both end the run.
                  if (last_q != len_hit)
                     tlast_err_q <= 1'b1;
                  state_q <= run_end ? ST_DONE : ST_WAIT_IN;
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      ss_tready = 1'b0;
      data_EN   = 1'b0;
      data_WE   = 4'h0;
      data_A    = '0;
      data_Di   = '0;
      smp_valid = 1'b0;
      ap_done   = 1'b0;
      case (state_q)
         ST_CLEAR: begin
            data_EN = 1'b1;
            data_WE = WE_ALL;
            data_A  = clr_ptr;
         end
         ST_WAIT_IN: ss_tready = 1'b1;
         ST_WRITE: begin
            data_EN = 1'b1;
            data_WE = WE_ALL;
            data_A  = head;
            data_Di = sample_q;
         end
         ST_NOTIFY: smp_valid = 1'b1;
         ST_DONE:   ap_done   = 1'b1;
         default: ;
      endcase
   end

   assign smp_head  = head;
   assign tlast_err = tlast_err_q;

endmodule

// File: tb/tb_fir_data_writer.sv
// Directed bench for fir_data_writer: clear pass, sample writes, head wrap,
// backpressure, tlast mismatch, zero-length run and reset mid-run.
module tb_fir_data_writer;

   logic        axis_clk = 1'b0;
   logic        axis_rst_n;
   logic        ap_start;
   logic [31:0] data_length;
   logic        ss_tvalid;
   logic [31:0] ss_tdata;
   logic        ss_tlast;
   logic        ss_tready;
   logic        data_EN;
   logic [3:0]  data_WE;
   logic [11:0] data_A;
   logic [31:0] data_Di;
   logic        smp_valid;
   logic [11:0] smp_head;
   logic        smp_ready;
   logic        ap_done;
   logic        tlast_err;

   int checks = 0;
   int errors = 0;

   logic [11:0] wa_q[$];
   logic [31:0] wd_q[$];
   int done_cnt   = 0;
   int tready_cnt = 0;
   int overlap    = 0;
   int bad_we     = 0;

   int wb, db, tb0;

   fir_data_writer dut (
      .axis_clk    (axis_clk),
      .axis_rst_n  (axis_rst_n),
      .ap_start    (ap_start),
      .data_length (data_length),
      .ss_tvalid   (ss_tvalid),
      .ss_tdata    (ss_tdata),
      .ss_tlast    (ss_tlast),
      .ss_tready   (ss_tready),
      .data_EN     (data_EN),
      .data_WE     (data_WE),
      .data_A      (data_A),
      .data_Di     (data_Di),
      .smp_valid   (smp_valid),
      .smp_head    (smp_head),
      .smp_ready   (smp_ready),
      .ap_done     (ap_done),
      .tlast_err   (tlast_err)
   );

   always #5 axis_clk = ~axis_clk;

   // Passive monitor sampled on the falling edge, away from state updates.
   always @(negedge axis_clk) begin
      if (data_EN) begin
         wa_q.push_back(data_A);
         wd_q.push_back(data_Di);
         if (data_WE !== 4'hF) bad_we++;
      end else if (data_WE !== 4'h0) begin
         bad_we++;
      end
      if (ap_done)   done_cnt++;
      if (ss_tready) tready_cnt++;
      if (ss_tready && smp_valid) overlap++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Starts a run and checks the 11-cycle clear window; returns at cycle 12.
   task automatic start_run(input logic [31:0] len);
      wb  = wa_q.size();
      db  = done_cnt;
      tb0 = tready_cnt;
      data_length = len;
      ap_start    = 1'b1;
      @(negedge axis_clk);
      ap_start = 1'b0;
      check("clr_first_en", data_EN, 1);
      check("clr_first_addr", data_A, 0);
      check("err_cleared", tlast_err, 0);
      repeat (10) @(negedge axis_clk);
      check("clr_last_addr", data_A, 32'h28);
      check("clr_no_tready", ss_tready, 0);
      @(negedge axis_clk);
      if (len == 0) begin
         check("len0_done_c12", ap_done, 1);
         check("len0_tready", ss_tready, 0);
      end else begin
         check("tready_c12", ss_tready, 1);
      end
   endtask

   task automatic send_sample(input logic [31:0] d, input logic last, input int dly,
                              input logic [11:0] exp_head, input bit hold);
      int t;
      t = 0;
      ss_tdata  = d;
      ss_tlast  = last;
      ss_tvalid = 1'b1;
      while (!ss_tready && t < 50) begin
         @(negedge axis_clk);
         t++;
      end
      check("tready_wait", 32'(t < 50), 1);
      @(negedge axis_clk);
      if (!hold) ss_tvalid = 1'b0;
      check("wr_addr", data_A, exp_head);
      check("wr_data", data_Di, d);
      @(negedge axis_clk);
      check("smp_valid", smp_valid, 1);
      check("smp_head", smp_head, exp_head);
      for (int i = 0; i < dly; i++) begin
         @(negedge axis_clk);
         check("smp_valid_hold", smp_valid, 1);
         check("tready_in_notify", ss_tready, 0);
      end
      smp_ready = 1'b1;
      @(negedge axis_clk);
      smp_ready = 1'b0;
      check("smp_valid_drop", smp_valid, 0);
   endtask

   task automatic check_clears();
      for (int i = 0; i < 11; i++) begin
         check("clr_addr", wa_q[wb + i], 32'(4 * i));
         check("clr_data", wd_q[wb + i], 0);
      end
   endtask

   initial begin
      axis_rst_n  = 1'b0;
      ap_start    = 1'b0;
      data_length = '0;
      ss_tvalid   = 1'b0;
      ss_tdata    = '0;
      ss_tlast    = 1'b0;
      smp_ready   = 1'b0;
      repeat (3) @(negedge axis_clk);

      check("rst_tready", ss_tready, 0);
      check("rst_en", data_EN, 0);
      check("rst_we", data_WE, 0);
      check("rst_valid", smp_valid, 0);
      check("rst_head", smp_head, 0);
      check("rst_done", ap_done, 0);
      check("rst_err", tlast_err, 0);
      axis_rst_n = 1'b1;
      repeat (2) @(negedge axis_clk);

      // Three samples, tlast on the third, ready two cycles after valid.
      start_run(32'd3);
      send_sample(32'hA5A5_0001, 1'b0, 2, 12'h000, 1'b0);
      send_sample(32'hA5A5_0002, 1'b0, 2, 12'h004, 1'b0);
      send_sample(32'hA5A5_0003, 1'b1, 2, 12'h008, 1'b0);
      check("t1_done_pulse", ap_done, 1);
      repeat (3) @(negedge axis_clk);
      check("t1_done_cnt", done_cnt - db, 1);
      check("t1_wr_cnt", wa_q.size() - wb, 14);
      check_clears();
      check("t1_s3_addr", wa_q[wb + 13], 32'h08);
      check("t1_s3_data", wd_q[wb + 13], 32'hA5A5_0003);
      check("t1_err", tlast_err, 0);

      // Thirteen samples, ready immediately: head wraps after 0x28.
      start_run(32'd13);
      for (int i = 1; i <= 13; i++)
         send_sample(32'(i), 1'(i == 13), 0, 12'(4 * ((i - 1) % 11)), 1'b0);
      repeat (3) @(negedge axis_clk);
      check("t2_wr_cnt", wa_q.size() - wb, 24);
      check("t2_s11_addr", wa_q[wb + 21], 32'h28);
      check("t2_s12_addr", wa_q[wb + 22], 32'h00);
      check("t2_s12_data", wd_q[wb + 22], 32'd12);
      check("t2_s13_addr", wa_q[wb + 23], 32'h04);
      check("t2_s13_data", wd_q[wb + 23], 32'd13);
      check("t2_done_cnt", done_cnt - db, 1);
      check("t2_err", tlast_err, 0);

      // ss_tvalid held high while ready is delayed five cycles.
      start_run(32'd2);
      send_sample(32'h0000_BEEF, 1'b0, 5, 12'h000, 1'b1);
      send_sample(32'h0000_CAFE, 1'b1, 5, 12'h004, 1'b1);
      ss_tvalid = 1'b0;
      repeat (3) @(negedge axis_clk);
      check("t3_wr_cnt", wa_q.size() - wb, 13);
      check("t3_s1_data", wd_q[wb + 11], 32'h0000_BEEF);
      check("t3_s2_data", wd_q[wb + 12], 32'h0000_CAFE);
      check("t3_overlap", overlap, 0);
      check("t3_done_cnt", done_cnt - db, 1);

      // Early tlast: run ends after one sample with a sticky error.
      start_run(32'd2);
      send_sample(32'h1234_5678, 1'b1, 1, 12'h000, 1'b0);
      check("t4_done_pulse", ap_done, 1);
      repeat (5) @(negedge axis_clk);
      check("t4_wr_cnt", wa_q.size() - wb, 12);
      check("t4_err_sticky", tlast_err, 1);
      check("t4_done_cnt", done_cnt - db, 1);

      // Zero-length run: clear pass only, error cleared by the new start.
      start_run(32'd0);
      repeat (3) @(negedge axis_clk);
      check("t5_wr_cnt", wa_q.size() - wb, 11);
      check_clears();
      check("t5_tready_cnt", tready_cnt - tb0, 0);
      check("t5_done_cnt", done_cnt - db, 1);

      // Missing tlast on the final sample of a huge-length run cannot occur;
      // tlast on sample 1 of a 0xFFFFFFFF run must flag early termination.
      start_run(32'hFFFF_FFFF);
      send_sample(32'h0000_0042, 1'b1, 0, 12'h000, 1'b0);
      check("t6_done_pulse", ap_done, 1);
      @(negedge axis_clk);
      check("t6_err", tlast_err, 1);

      // Missing tlast on the last sample also flags the error.
      start_run(32'd1);
      send_sample(32'h0000_0077, 1'b0, 0, 12'h000, 1'b0);
      check("t7_done_pulse", ap_done, 1);
      @(negedge axis_clk);
      check("t7_err", tlast_err, 1);
      repeat (2) @(negedge axis_clk);

      // Reset while in NOTIFY abandons the run silently.
      start_run(32'd3);
      ss_tdata  = 32'h0000_0099;
      ss_tlast  = 1'b0;
      ss_tvalid = 1'b1;
      @(negedge axis_clk);
      ss_tvalid = 1'b0;
      @(negedge axis_clk);
      check("t8_in_notify", smp_valid, 1);
      #2 axis_rst_n = 1'b0;
      #1;
      check("t8_rst_valid", smp_valid, 0);
      check("t8_rst_tready", ss_tready, 0);
      check("t8_rst_en", data_EN, 0);
      @(negedge axis_clk);
      axis_rst_n = 1'b1;
      repeat (5) @(negedge axis_clk);
      check("t8_no_done", done_cnt - db, 0);
      check("t8_idle_tready", ss_tready, 0);

      check("we_decode", bad_we, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
